// File: rtl/subway_pkg.sv
// Shared state encoding for the subway block-section occupancy controller.
package subway_pkg;
    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_EAST  = 2'd1,
        ST_WEST  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;
endpackage

// File: rtl/subway_track_ctrl.sv
// One track: two sensor debouncers, edge detect, direction-locking FSM,
// occupancy counter and idle-occupied watchdog.
module subway_track_ctrl
    import subway_pkg::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 3,
    parameter int TIMEOUT  = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p1,
    input  logic             p2,
    input  logic             clr_fault,
    output logic             out,
    output logic             dir,
    output logic [CNT_W-1:0] occ_cnt,
    output logic             fault,
    output logic [ST_W-1:0]  crnt_st
);
    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0]  WD_LIM  = TO_W'(TIMEOUT);

    // Bit 0 is the west sensor p1, bit 1 the east sensor p2.
    logic [1:0] w_raw;
    logic [1:0] w_filt;
    logic [1:0] w_filt_d;
    logic [1:0] w_rise;
    logic [1:0] w_fall;

    assign w_raw = {p2, p1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_db
            logic            r_filt;
            logic            r_filt_d;
            logic [DB_W-1:0] r_db_cnt;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_filt   <= 1'b0;
                    r_filt_d <= 1'b0;
                    r_db_cnt <= '0;
                end else begin
                    r_filt_d <= r_filt;
                    if (w_raw[gi] != r_filt) begin
                        if (r_db_cnt == DB_LAST) begin
                            r_filt   <= w_raw[gi];
                            r_db_cnt <= '0;
                        end else begin
                            r_db_cnt <= r_db_cnt + 1'b1;
                        end
                    end else begin
                        r_db_cnt <= '0;
                    end
                end
            end

            assign w_filt[gi]   = r_filt;
            assign w_filt_d[gi] = r_filt_d;
        end
    endgenerate

    assign w_rise = w_filt & ~w_filt_d;
    assign w_fall = ~w_filt & w_filt_d;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_dir, w_dir_next;
    logic [TO_W-1:0]  r_wd, w_wd_next;
    logic             r_out, r_fault;
    logic             w_any_edge, w_entry_rise, w_exit_fall;

    assign w_any_edge   = |(w_rise | w_fall);
    assign w_entry_rise = (r_state == ST_EAST) ? w_rise[0] : w_rise[1];
    assign w_exit_fall  = (r_state == ST_EAST) ? w_fall[1] : w_fall[0];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_dir_next   = r_dir;
        w_wd_next    = (w_any_edge || r_state == ST_IDLE || r_state == ST_FAULT)
                       ? '0 : r_wd + 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_rise[0] && w_rise[1]) begin
                    w_state_next = ST_FAULT;
                end else if (w_rise[0]) begin
                    w_state_next = ST_EAST;
                    w_cnt_next   = CNT_W'(1);
                    w_dir_next   = 1'b0;
                end else if (w_rise[1]) begin
                    w_state_next = ST_WEST;
                    w_cnt_next   = CNT_W'(1);
                    w_dir_next   = 1'b1;
                end
            end
            ST_EAST, ST_WEST: begin
                // A train entering while another leaves nets to zero change.
                if (w_entry_rise && !w_exit_fall) begin
                    if (r_cnt == CNT_MAX) w_state_next = ST_FAULT;
                    else                  w_cnt_next   = r_cnt + 1'b1;
                end else if (w_exit_fall && !w_entry_rise) begin
                    if (r_cnt == '0) begin
                        w_state_next = ST_FAULT;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) w_state_next = ST_IDLE;
                    end
                end
                if (w_wd_next == WD_LIM) w_state_next = ST_FAULT;
            end
            ST_FAULT: begin
                if (clr_fault && w_filt == 2'b00) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: w_state_next = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_wd    <= '0;
            r_out   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_dir   <= w_dir_next;
            r_wd    <= w_wd_next;
            r_out   <= (w_state_next != ST_IDLE);
            r_fault <= (w_state_next == ST_FAULT);
        end
    end

    assign out     = r_out;
    assign dir     = r_dir;
    assign occ_cnt = r_cnt;
    assign fault   = r_fault;
    assign crnt_st = r_state;
endmodule

// File: rtl/subway_multitrack_ctrl.sv
// Multi-track occupancy controller: N_TRACKS independent track controllers
// with their outputs packed into flat buses.
module subway_multitrack_ctrl
    import subway_pkg::*;
#(
    parameter int N_TRACKS = 4,
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 3,
    parameter int TIMEOUT  = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_TRACKS-1:0]       p1,
    input  logic [N_TRACKS-1:0]       p2,
    input  logic [N_TRACKS-1:0]       clr_fault,
    output logic [N_TRACKS-1:0]       out,
    output logic [N_TRACKS-1:0]       dir,
    output logic [N_TRACKS*CNT_W-1:0] occ_cnt,
    output logic [N_TRACKS-1:0]       fault,
    output logic [N_TRACKS*ST_W-1:0]  crntSt
);
    generate
        for (genvar gi = 0; gi < N_TRACKS; gi++) begin : g_trk
            subway_track_ctrl #(
                .DEBOUNCE (DEBOUNCE),
                .CNT_W    (CNT_W),
                .TIMEOUT  (TIMEOUT)
            ) u_trk (
                .clk       (clk),
                .reset     (reset),
                .p1        (p1[gi]),
                .p2        (p2[gi]),
                .clr_fault (clr_fault[gi]),
                .out       (out[gi]),
                .dir       (dir[gi]),
                .occ_cnt   (occ_cnt[gi*CNT_W +: CNT_W]),
                .fault     (fault[gi]),
                .crnt_st   (crntSt[gi*ST_W +: ST_W])
            );
        end
    endgenerate
endmodule

// File: tb/tb_subway_multitrack_ctrl.sv
// Directed bench for subway_multitrack_ctrl with 2 tracks, DEBOUNCE=3,
// CNT_W=2, TIMEOUT=20; expected values are hand-computed constants.
module tb_subway_multitrack_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] p1, p2, clr_fault;
    logic [1:0] out, dir, fault;
    logic [3:0] occ_cnt, crnt_st;

    int n_checks = 0;
    int n_pass   = 0;

    subway_multitrack_ctrl #(
        .N_TRACKS (2),
        .DEBOUNCE (3),
        .CNT_W    (2),
        .TIMEOUT  (20)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .p1        (p1),
        .p2        (p2),
        .clr_fault (clr_fault),
        .out       (out),
        .dir       (dir),
        .occ_cnt   (occ_cnt),
        .fault     (fault),
        .crntSt    (crnt_st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-18s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("FAIL %-18s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; p1 = '0; p2 = '0; clr_fault = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        rst_n = 1'b0; p1 = 2'b01; p2 = '0; clr_fault = '0;
        // Reset with p1[0] held high, then re-filter after release.
        tick(3);
        chk("rst_out",   32'(out),     32'h0);
        chk("rst_cnt",   32'(occ_cnt), 32'h0);
        chk("rst_fault", 32'(fault),   32'h0);
        chk("rst_state", 32'(crnt_st), 32'h0);
        rst_n = 1'b1;
        tick(3);
        chk("rel_out_early", 32'(out), 32'h0);
        tick(1);
        chk("rel_out", 32'(out), 32'h1);
        chk("rel_cnt", 32'(occ_cnt), 32'h1);

        // Eastbound pass on track 0.
        do_reset();
        p1[0] = 1'b1;
        tick(4);
        chk("east_out",   32'(out),     32'h1);
        chk("east_cnt",   32'(occ_cnt), 32'h1);
        chk("east_dir",   32'(dir),     32'h0);
        chk("east_state", 32'(crnt_st), 32'h1);
        tick(1);
        p1[0] = 1'b0;
        tick(4);
        p2[0] = 1'b1;
        tick(5);
        p2[0] = 1'b0;
        tick(3);
        chk("exit_out_early", 32'(out), 32'h1);
        tick(1);
        chk("exit_out",   32'(out),     32'h0);
        chk("exit_cnt",   32'(occ_cnt), 32'h0);
        chk("exit_state", 32'(crnt_st), 32'h0);

        // Two-cycle glitch must be discarded.
        do_reset();
        p1[0] = 1'b1;
        tick(2);
        p1[0] = 1'b0;
        tick(6);
        chk("glitch_out",   32'(out),     32'h0);
        chk("glitch_cnt",   32'(occ_cnt), 32'h0);
        chk("glitch_state", 32'(crnt_st), 32'h0);

        // Overflow: three entries fill the section, the fourth faults.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            p1[0] = 1'b1; tick(4);
            p1[0] = 1'b0; tick(4);
        end
        chk("ovf_cnt3",  32'(occ_cnt), 32'h3);
        chk("ovf_state", 32'(crnt_st), 32'h1);
        p1[0] = 1'b1;
        tick(4);
        chk("ovf_fault", 32'(fault),   32'h1);
        chk("ovf_hold",  32'(occ_cnt), 32'h3);
        chk("ovf_out",   32'(out),     32'h1);
        clr_fault[0] = 1'b1; tick(1); clr_fault[0] = 1'b0;
        chk("clr_ignored", 32'(fault), 32'h1);
        p1[0] = 1'b0;
        tick(4);
        clr_fault[0] = 1'b1; tick(1); clr_fault[0] = 1'b0;
        chk("clr_state", 32'(crnt_st), 32'h0);
        chk("clr_cnt",   32'(occ_cnt), 32'h0);
        chk("clr_fault", 32'(fault),   32'h0);
        chk("clr_out",   32'(out),     32'h0);

        // Track 0 eastbound, track 1 westbound at the same time.
        do_reset();
        p1[0] = 1'b1; p2[1] = 1'b1;
        tick(4);
        chk("conc_dir",   32'(dir),     32'h2);
        chk("conc_cnt",   32'(occ_cnt), 32'h5);
        chk("conc_state", 32'(crnt_st), 32'h9);
        p1[0] = 1'b0; p2[1] = 1'b0;
        tick(4);
        p1[0] = 1'b1;
        tick(4);
        chk("conc_cnt2", 32'(occ_cnt), 32'h6);
        p1[0] = 1'b0; p2[0] = 1'b1;
        tick(4);
        p1[0] = 1'b1; p2[0] = 1'b0;
        tick(4);
        chk("simul_cnt",   32'(occ_cnt), 32'h6);
        chk("simul_state", 32'(crnt_st), 32'h9);

        // Watchdog: single entry, then no further filtered edges.
        do_reset();
        p1[0] = 1'b1;
        tick(4);
        chk("wd_entry", 32'(crnt_st), 32'h1);
        tick(19);
        chk("wd_early", 32'(fault), 32'h0);
        tick(1);
        chk("wd_fault", 32'(fault),   32'h1);
        chk("wd_state", 32'(crnt_st), 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
